// File: rtl/decoder_3x8_strobe_pkg.sv
// rtl/decoder_3x8_strobe_pkg.sv - shared types and helpers for the strobed 3-to-8 decoder
package decoder_3x8_strobe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef logic [2:0] code_t;
    typedef logic [7:0] onehot_t;

    // Bits needed to hold any value up to max(hold, gap).
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        int w;
        m = (hold > gap) ? hold : gap;
        w = 1;
        while ((1 << w) <= m) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/decoder_3x8_strobe_dec3to8.sv
// rtl/decoder_3x8_strobe_dec3to8.sv - combinational 3-to-8 one-hot decoder
module dec3to8
    import decoder_3x8_strobe_pkg::*;
(
    input  code_t   code,
    output onehot_t onehot
);

    assign onehot = onehot_t'(1) << code;

endmodule

// File: rtl/decoder_3x8_strobe.sv
// rtl/decoder_3x8_strobe.sv - registered 3-to-8 decoder with handshake and timed strobes
module decoder_3x8_strobe
    import decoder_3x8_strobe_pkg::*;
#(
    parameter int HOLD = 4,
    parameter int GAP  = 1
)
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  logic    in_valid,
    output logic    in_ready,
    input  code_t   in_code,
    output onehot_t y,
    output logic    busy,
    output logic    done
);

    localparam int CW = cnt_width(HOLD, GAP);

    if (HOLD < 1 || HOLD > 255 || GAP < 0 || GAP > 255) begin : g_param_check
        $error("decoder_3x8_strobe: HOLD must be 1..255 and GAP 0..255");
    end

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    onehot_t         y_n;
    logic            done_n;
    onehot_t         dec_out;

    dec3to8 u_dec (
        .code   (in_code),
        .onehot (dec_out)
    );

    // rst gates in_ready so nothing looks acceptable while the block is held in reset
    assign in_ready = en && !rst && (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            y     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            y     <= y_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        y_n     = y;
        done_n  = 1'b0;
        if (!en) begin
            // abort wins over a completion landing on the same edge
            state_n = ST_IDLE;
            cnt_n   = '0;
            y_n     = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        y_n     = dec_out;
                        cnt_n   = CW'(HOLD - 1);
                        state_n = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - CW'(1);
                    end else begin
                        y_n    = '0;
                        done_n = 1'b1;
                        if (GAP > 0) begin
                            state_n = ST_GAP;
                            cnt_n   = CW'(GAP - 1);
                        end else begin
                            state_n = ST_IDLE;
                            cnt_n   = '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - CW'(1);
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    y_n     = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_3x8_strobe.sv
// tb/tb_decoder_3x8_strobe.sv - self-checking bench for decoder_3x8_strobe
module tb_decoder_3x8_strobe;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic [2:0] in_code;

    logic       in_ready_a, busy_a, done_a;
    logic [7:0] y_a;
    logic       in_ready_b, busy_b, done_b;
    logic [7:0] y_b;

    int chk = 0;
    int err = 0;

    always #5 clk = ~clk;

    decoder_3x8_strobe #(.HOLD(4), .GAP(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_code(in_code), .y(y_a), .busy(busy_a), .done(done_a)
    );

    decoder_3x8_strobe #(.HOLD(1), .GAP(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_code(in_code), .y(y_b), .busy(busy_b), .done(done_b)
    );

    // Timeline model: a strobe accepted at edge k=0 is one-hot for k<HOLD,
    // pulses done at k==HOLD, and keeps the block busy while k<HOLD+GAP.
    int         hold_of [2] = '{4, 1};
    int         gap_of  [2] = '{1, 0};
    bit         m_act   [2] = '{0, 0};
    int         m_k     [2] = '{0, 0};
    logic [2:0] m_code  [2] = '{3'd0, 3'd0};

    function automatic bit m_busy(input int d);
        return m_act[d] && (m_k[d] < hold_of[d] + gap_of[d]);
    endfunction

    task automatic model_edge(input int d);
        bit bz;
        bz = m_busy(d);
        if (rst || !en) begin
            m_act[d] = 0;
        end else if (in_valid && !bz) begin
            m_act[d]  = 1;
            m_k[d]    = 0;
            m_code[d] = in_code;
        end else if (m_act[d] && m_k[d] < 1000) begin
            m_k[d] = m_k[d] + 1;
        end
    endtask

    task automatic model_reset();
        m_act[0] = 0;
        m_act[1] = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int d);
        logic [7:0] yy, ey;
        logic       dd, bb, rr;
        yy = (d == 0) ? y_a : y_b;
        dd = (d == 0) ? done_a : done_b;
        bb = (d == 0) ? busy_a : busy_b;
        rr = (d == 0) ? in_ready_a : in_ready_b;
        ey = (m_act[d] && m_k[d] < hold_of[d]) ? (8'h01 << m_code[d]) : 8'h00;
        check($sformatf("model_y[%0d]", d), yy, ey);
        check($sformatf("model_done[%0d]", d), dd, m_act[d] && m_k[d] == hold_of[d]);
        check($sformatf("model_busy[%0d]", d), bb, m_busy(d));
        check($sformatf("model_ready[%0d]", d), rr, en && !rst && !m_busy(d));
        check($sformatf("onehot[%0d]", d), $countones(yy) <= 1, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    typedef struct {
        logic       en;
        logic       v;
        logic [2:0] c;
        logic [7:0] y;
        logic       d;
        logic       b;
        logic       r;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [7:0] seq [$];
        logic [7:0] prev_y;
        int idx, dones, n80, accepted, ny, nd;
        bit acc;

        tbl[0]  = '{1'b1, 1'b1, 3'd5, 8'h20, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 3'd5, 8'h20, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'd5, 8'h20, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'd5, 8'h20, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'd5, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 3'd1, 8'h02, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 3'd1, 8'h02, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_code = 3'd0;
        #1;
        check("rst_y", y_a, 8'h00);
        check("rst_done", done_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_ready_a", in_ready_a, 1'b0);
        check("rst_ready_b", in_ready_b, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", in_ready_a, 1'b1);

        // basic strobe, back-to-back accept, then abort in the 2nd hold cycle
        for (int i = 0; i < 11; i++) begin
            en = tbl[i].en; in_valid = tbl[i].v; in_code = tbl[i].c;
            tick();
            check($sformatf("tbl%0d_y", i), y_a, tbl[i].y);
            check($sformatf("tbl%0d_done", i), done_a, tbl[i].d);
            check($sformatf("tbl%0d_busy", i), busy_a, tbl[i].b);
            check($sformatf("tbl%0d_ready", i), in_ready_a, tbl[i].r);
        end

        // asynchronous reset mid-strobe
        en = 1'b1; in_valid = 1'b1; in_code = 3'd2;
        tick();
        in_valid = 1'b0;
        tick();
        check("pre_rst_y", y_a, 8'h04);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("arst_y", y_a, 8'h00);
        check("arst_done", done_a, 1'b0);
        check("arst_busy", busy_a, 1'b0);
        check("arst_ready", in_ready_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_release_ready", in_ready_a, 1'b1);

        // sweep codes 0..7 with in_valid held high
        idx = 0; dones = 0; prev_y = y_a;
        in_valid = 1'b1; in_code = 3'd0;
        for (int n = 0; n < 200 && !(idx == 8 && !m_busy(0)); n++) begin
            acc = in_valid && in_ready_a;
            tick();
            if (acc) idx++;
            if (idx < 8) in_code = idx[2:0];
            else in_valid = 1'b0;
            if (y_a != 8'h00 && prev_y == 8'h00) seq.push_back(y_a);
            if (done_a) dones++;
            prev_y = y_a;
        end
        check("sweep_accepts", idx, 8);
        check("sweep_strobes", seq.size(), 8);
        check("sweep_dones", dones, 8);
        for (int i = 0; i < 8 && i < seq.size(); i++)
            check($sformatf("sweep_y%0d", i), seq[i], 8'h01 << i);

        // backpressure: code 7 waits while busy, then exactly one strobe
        in_valid = 1'b1; in_code = 3'd1;
        tick();
        check("bp_first", y_a, 8'h02);
        in_code = 3'd7;
        n80 = 0; accepted = 0;
        for (int n = 0; n < 30; n++) begin
            acc = in_valid && in_ready_a;
            tick();
            if (acc) begin
                in_valid = 1'b0;
                accepted++;
            end
            if (y_a == 8'h80) n80++;
        end
        check("bp_accepts", accepted, 1);
        check("bp_hold_cycles", n80, 4);

        // minimum period on the HOLD=1, GAP=0 instance
        in_valid = 1'b0;
        repeat (3) tick();
        in_valid = 1'b1;
        ny = 0; nd = 0;
        for (int n = 0; n < 20; n++) begin
            in_code = 3'($urandom_range(0, 7));
            tick();
            check($sformatf("minp_alt%0d", n), y_b != 8'h00, (n % 2) == 0);
            if (y_b != 8'h00) ny++;
            if (done_b) nd++;
        end
        check("minp_strobes", ny, 10);
        check("minp_dones", nd, 10);

        // randomized traffic with occasional aborts and async resets
        for (int n = 0; n < 400; n++) begin
            en       = ($urandom_range(0, 7) != 0);
            in_valid = $urandom_range(0, 1);
            in_code  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b1;
                model_reset();
                #1 rst = 1'b0;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
